// File: rtl/motor_drive_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : motor_drive_ctrl
//  Purpose  : Executes stop/forward/backward drive commands with a duty value
//             on one H-bridge channel. Motion toward a side that the
//             synchronised collision flags report as blocked is refused or
//             aborted. A brake dead-time is inserted on every stop or reversal.
//  Ports    : clk, rst         - clock, synchronous active-high reset
//             cmd_valid/ready  - command handshake (accept on valid & ready)
//             cmd_dir/cmd_duty - 00 stop, 01 fwd, 10 bwd, 11 stop; duty value
//             col_front/rear   - asynchronous collision flags
//             pwm, dir_a/dir_b - motor enable and bridge legs (registered)
//             busy, blocked    - not-idle flag; one-cycle refusal pulse
//  Revision : 1.0 - initial release
// ============================================================================
module motor_drive_ctrl #(
  parameter int PWM_BITS     = 8,
  parameter int DEADTIME_CYC = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_dir,
  input  logic [PWM_BITS-1:0] cmd_duty,
  input  logic                col_front,
  input  logic                col_rear,
  output logic                pwm,
  output logic                dir_a,
  output logic                dir_b,
  output logic                busy,
  output logic                blocked
);

  localparam int            c_DT_W    = (DEADTIME_CYC > 1) ? $clog2(DEADTIME_CYC) : 1;
  localparam logic [c_DT_W-1:0] c_DT_LAST = c_DT_W'(DEADTIME_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FWD   = 2'd1,
    S_BWD   = 2'd2,
    S_BRAKE = 2'd3
  } state_t;

  // Pending target after BRAKE reuses the state encoding; S_IDLE means "none".
  state_t                r_state, w_state_nxt;
  state_t                r_pend,  w_pend_nxt;
  logic [PWM_BITS-1:0]   r_duty,  w_duty_nxt;
  logic [c_DT_W-1:0]     r_dt,    w_dt_nxt;
  logic [PWM_BITS-1:0]   r_cnt,   w_cnt_nxt;
  logic                  w_blk_nxt;

  logic r_cf_meta, r_cf_s, r_cr_meta, r_cr_s;
  logic r_pwm, r_dir_a, r_dir_b, r_busy, r_blocked, r_ready;

  logic w_acc, w_cmd_fwd, w_cmd_bwd, w_cmd_stop, w_moving_nxt;

  assign w_acc      = cmd_valid & r_ready;
  assign w_cmd_fwd  = w_acc & (cmd_dir == 2'b01);
  assign w_cmd_bwd  = w_acc & (cmd_dir == 2'b10);
  assign w_cmd_stop = w_acc & ((cmd_dir == 2'b00) | (cmd_dir == 2'b11));
  assign w_cnt_nxt  = r_cnt + PWM_BITS'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend;
    w_duty_nxt  = r_duty;
    w_dt_nxt    = r_dt;
    w_blk_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cmd_fwd) begin
          if (r_cf_s) w_blk_nxt = 1'b1;
          else begin
            w_state_nxt = S_FWD;
            w_duty_nxt  = cmd_duty;
          end
        end else if (w_cmd_bwd) begin
          if (r_cr_s) w_blk_nxt = 1'b1;
          else begin
            w_state_nxt = S_BWD;
            w_duty_nxt  = cmd_duty;
          end
        end
      end
      S_FWD, S_BWD: begin
        // A collision on the side we are moving toward overrides any command
        // accepted in the same cycle; that command is simply dropped.
        if ((r_state == S_FWD) ? r_cf_s : r_cr_s) begin
          w_state_nxt = S_BRAKE;
          w_pend_nxt  = S_IDLE;
          w_dt_nxt    = '0;
          w_blk_nxt   = 1'b1;
        end else if ((r_state == S_FWD) ? w_cmd_fwd : w_cmd_bwd) begin
          w_duty_nxt = cmd_duty;
        end else if ((r_state == S_FWD) ? w_cmd_bwd : w_cmd_fwd) begin
          w_state_nxt = S_BRAKE;
          w_pend_nxt  = (r_state == S_FWD) ? S_BWD : S_FWD;
          w_duty_nxt  = cmd_duty;
          w_dt_nxt    = '0;
        end else if (w_cmd_stop) begin
          w_state_nxt = S_BRAKE;
          w_pend_nxt  = S_IDLE;
          w_dt_nxt    = '0;
        end
      end
      S_BRAKE: begin
        if (r_dt == c_DT_LAST) begin
          w_pend_nxt = S_IDLE;
          if (r_pend == S_FWD) begin
            w_state_nxt = r_cf_s ? S_IDLE : S_FWD;
            w_blk_nxt   = r_cf_s;
          end else if (r_pend == S_BWD) begin
            w_state_nxt = r_cr_s ? S_IDLE : S_BWD;
            w_blk_nxt   = r_cr_s;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_dt_nxt = r_dt + c_DT_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_moving_nxt = (w_state_nxt == S_FWD) | (w_state_nxt == S_BWD);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cf_meta <= 1'b0;
      r_cf_s    <= 1'b0;
      r_cr_meta <= 1'b0;
      r_cr_s    <= 1'b0;
      r_state   <= S_IDLE;
      r_pend    <= S_IDLE;
      r_duty    <= '0;
      r_dt      <= '0;
      r_cnt     <= '0;
      r_pwm     <= 1'b0;
      r_dir_a   <= 1'b0;
      r_dir_b   <= 1'b0;
      r_busy    <= 1'b0;
      r_blocked <= 1'b0;
      r_ready   <= 1'b0;
    end else begin
      r_cf_meta <= col_front;
      r_cf_s    <= r_cf_meta;
      r_cr_meta <= col_rear;
      r_cr_s    <= r_cr_meta;
      r_state   <= w_state_nxt;
      r_pend    <= w_pend_nxt;
      r_duty    <= w_duty_nxt;
      r_dt      <= w_dt_nxt;
      r_cnt     <= w_cnt_nxt;
      // Outputs are decoded from the next state so they line up with it.
      r_pwm     <= w_moving_nxt & (w_cnt_nxt < w_duty_nxt);
      r_dir_a   <= (w_state_nxt == S_FWD) | (w_state_nxt == S_BRAKE);
      r_dir_b   <= (w_state_nxt == S_BWD) | (w_state_nxt == S_BRAKE);
      r_busy    <= (w_state_nxt != S_IDLE);
      r_blocked <= w_blk_nxt;
      r_ready   <= (w_state_nxt != S_BRAKE);
    end
  end

  assign cmd_ready = r_ready;
  assign pwm       = r_pwm;
  assign dir_a     = r_dir_a;
  assign dir_b     = r_dir_b;
  assign busy      = r_busy;
  assign blocked   = r_blocked;

endmodule
`default_nettype wire

// File: tb/tb_motor_drive_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_motor_drive_ctrl
//  Purpose  : Self-checking bench for motor_drive_ctrl against a behavioural
//             model of the drive rules (directed scenarios plus random run).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_motor_drive_ctrl;

  localparam int c_DT = 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_dir = 2'b00;
  logic [7:0] cmd_duty = 8'd0;
  logic       col_front = 1'b0;
  logic       col_rear = 1'b0;
  logic       pwm, dir_a, dir_b, busy, blocked;

  int n_vec = 0;
  int n_err = 0;

  motor_drive_ctrl #(.PWM_BITS(8), .DEADTIME_CYC(c_DT)) u_dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_duty(cmd_duty), .col_front(col_front),
    .col_rear(col_rear), .pwm(pwm), .dir_a(dir_a), .dir_b(dir_b),
    .busy(busy), .blocked(blocked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model. Mode: 0 idle, 1 forward, 2 backward, 3 braking.
  // Pending motion after braking: 0 none, 1 forward, 2 backward.
  int m_mode = 0, m_pend = 0, m_duty = 0, m_left = 0, m_edges = 0;
  bit m_cf_hist[2] = '{0, 0};   // [0] newest sample, [1] synchronised value
  bit m_cr_hist[2] = '{0, 0};
  bit m_ready = 0, m_blk = 0;

  function automatic bit side_blocked(int dir);
    return (dir == 1) ? m_cf_hist[1] : m_cr_hist[1];
  endfunction

  task automatic model_edge();
    int req;
    m_blk = 0;
    if (rst) begin
      m_mode = 0; m_pend = 0; m_duty = 0; m_left = 0; m_edges = 0;
      m_cf_hist = '{0, 0}; m_cr_hist = '{0, 0}; m_ready = 0;
      return;
    end
    req = -1;
    if (cmd_valid && m_ready) req = (cmd_dir == 2'b01) ? 1 : (cmd_dir == 2'b10) ? 2 : 0;
    if (m_mode == 0) begin
      if (req == 1 || req == 2) begin
        if (side_blocked(req)) m_blk = 1;
        else begin m_mode = req; m_duty = cmd_duty; end
      end
    end else if (m_mode == 1 || m_mode == 2) begin
      if (side_blocked(m_mode)) begin
        m_mode = 3; m_pend = 0; m_left = c_DT; m_blk = 1;
      end else if (req == m_mode) m_duty = cmd_duty;
      else if (req == 3 - m_mode) begin
        m_pend = req; m_mode = 3; m_left = c_DT; m_duty = cmd_duty;
      end else if (req == 0) begin
        m_pend = 0; m_mode = 3; m_left = c_DT;
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        if (m_pend == 0) m_mode = 0;
        else if (side_blocked(m_pend)) begin m_mode = 0; m_blk = 1; end
        else m_mode = m_pend;
        m_pend = 0;
      end
    end
    m_edges++;
    m_cf_hist[1] = m_cf_hist[0]; m_cf_hist[0] = col_front;
    m_cr_hist[1] = m_cr_hist[0]; m_cr_hist[0] = col_rear;
    m_ready = (m_mode != 3);
  endtask

  task automatic cyc();
    bit moving;
    @(posedge clk);
    model_edge();
    #1;
    moving = (m_mode == 1 || m_mode == 2);
    chk("pwm",       int'(pwm),       int'(moving && ((m_edges % 256) < m_duty)));
    chk("dir_a",     int'(dir_a),     int'(m_mode == 1 || m_mode == 3));
    chk("dir_b",     int'(dir_b),     int'(m_mode == 2 || m_mode == 3));
    chk("busy",      int'(busy),      int'(m_mode != 0));
    chk("blocked",   int'(blocked),   int'(m_blk));
    chk("cmd_ready", int'(cmd_ready), int'(m_ready));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic send(input logic [1:0] d, input logic [7:0] du);
    cmd_valid = 1'b1; cmd_dir = d; cmd_duty = du;
    cyc();
    cmd_valid = 1'b0;
  endtask

  initial begin
    int n;
    // 1: reset held three cycles, then released
    rst = 1'b1;
    run(3);
    chk("rst_pwm", int'(pwm), 0);
    chk("rst_ready", int'(cmd_ready), 0);
    rst = 1'b0;
    cyc();
    chk("ready_after_rst", int'(cmd_ready), 1);

    // 2: forward, duty 64
    send(2'b01, 8'd64);
    chk("fwd_dir", int'({dir_a, dir_b}), 2);
    n = 0;
    for (int i = 0; i < 256; i++) begin cyc(); if (pwm) n++; end
    chk("pwm_hi_64", n, 64);

    // 3: reversal through brake
    send(2'b10, 8'd128);
    n = 1;
    for (int i = 0; i < 1100 && dir_a && dir_b; i++) begin
      if (cmd_ready) n = -10000;
      cyc();
      if (dir_a && dir_b) n++;
    end
    chk("brake_len", n, c_DT);
    chk("bwd_dir", int'({dir_a, dir_b}), 1);
    n = 0;
    for (int i = 0; i < 256; i++) begin cyc(); if (pwm) n++; end
    chk("pwm_hi_128", n, 128);

    // 4: front collision while moving forward, rear collision ignored
    send(2'b00, 8'd0);
    run(c_DT + 2);
    send(2'b01, 8'd200);
    run(5);
    col_front = 1'b1;
    run(3);
    chk("col_brake", int'({dir_a, dir_b}), 3);
    col_front = 1'b0;
    run(c_DT + 2);
    send(2'b01, 8'd30);
    col_rear = 1'b1;
    run(20);
    chk("rear_ignored", int'({dir_a, dir_b}), 2);

    // 5: idle with rear blocked; backward refused, reserved ignored
    send(2'b11, 8'd99);
    run(c_DT + 2);
    send(2'b10, 8'd77);
    chk("refused_blk", int'(blocked), 1);
    chk("refused_busy", int'(busy), 0);
    send(2'b11, 8'd5);
    run(3);
    col_rear = 1'b0;
    run(3);

    // 6: reset mid-brake with a pending forward move
    send(2'b10, 8'd50);
    run(10);
    send(2'b01, 8'd100);
    run(10);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    run(3);
    chk("rst_brake_dir", int'({dir_a, dir_b}), 0);
    run(c_DT + 10);

    // Random traffic against the model
    for (int i = 0; i < 20000; i++) begin
      cmd_valid = ($urandom % 6 == 0);
      cmd_dir   = 2'($urandom);
      case ($urandom % 4)
        0: cmd_duty = 8'd0;
        1: cmd_duty = 8'd255;
        default: cmd_duty = 8'($urandom);
      endcase
      if ($urandom % 400 == 0) col_front = ~col_front;
      if ($urandom % 400 == 0) col_rear  = ~col_rear;
      rst = ($urandom % 5000 == 0);
      cyc();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
